// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: op encodings, FSM states and default sizing for the shift sequencer.
package shift_seq_pkg;
  localparam int WIDTH_DEF = 6;
  localparam int AMT_W_DEF = 3;
  localparam int STEP_DEF = 2;
  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift/rotate of data by a small amount k.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int KW = 2
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] out
);
  logic [2*WIDTH-1:0] rol, ror;
  // Rotates shift a doubled copy so wrapped bits land in the kept half.
  assign rol = {data, data} << k;
  assign ror = {data, data} >> k;
  assign out = (op == OP_LSL) ? data << k :
               (op == OP_LSR) ? data >> k :
               (op == OP_ROL) ? rol[2*WIDTH-1:WIDTH] : ror[WIDTH-1:0];
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: accepts one shift request, applies it STEP bits per cycle, returns the result.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF,
  parameter int STEP = STEP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);
  localparam int KW = $clog2(STEP + 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, step_out;
  logic [AMT_W-1:0] rem_q, rem_d, k_full, rem_nxt;
  logic [1:0] op_q, op_d;
  assign req_ready = (state_q == IDLE) && !flush;
  assign rsp_valid = (state_q == DONE);
  assign busy = (state_q != IDLE);
  assign rsp_data = data_q;
  assign k_full = (rem_q < AMT_W'(STEP)) ? rem_q : AMT_W'(STEP);
  assign rem_nxt = rem_q - k_full;
  shift_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
    .data(data_q),
    .op(op_q),
    .k(k_full[KW-1:0]),
    .out(step_out)
  );
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    rem_d = rem_q;
    op_d = op_q;
    if (flush) begin
      state_d = IDLE;
      rem_d = '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          data_d = req_data;
          op_d = req_op;
          rem_d = req_amt;
          state_d = (req_amt != '0) ? SHIFT : DONE;
        end
        SHIFT: begin
          data_d = step_out;
          rem_d = rem_nxt;
          state_d = (rem_nxt == '0) ? DONE : SHIFT;
        end
        DONE: state_d = rsp_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      rem_q <= '0;
      op_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      rem_q <= rem_d;
      op_q <= op_d;
    end
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed vectors with hand-computed results, latency, stall, flush and reset.
module tb_shift_seq_ctrl;
  logic clk = 0, rst_n = 0, flush = 0, req_valid = 0, rsp_ready = 0;
  logic req_ready, rsp_valid, busy;
  logic [5:0] req_data = '0, rsp_data;
  logic [2:0] req_amt = '0;
  logic [1:0] req_op = '0;
  int total = 0, bad = 0;

  shift_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_amt(req_amt), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [5:0] d, input logic [1:0] op, input logic [2:0] amt,
                     input logic [5:0] exp, input int lat);
    int n;
    req_data = d; req_op = op; req_amt = amt; req_valid = 1;
    chk("accept_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 0; req_data = ~d; req_op = ~op; req_amt = ~amt;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("rsp_data", 32'(rsp_data), 32'(exp));
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("back_idle", 32'({busy, rsp_valid}), 0);
  endtask

  initial begin
    #2;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);

    run(6'b001000, 2'b00, 3'd2, 6'b100000, 2);
    run(6'b001000, 2'b01, 3'd3, 6'b000001, 3);
    run(6'b100001, 2'b10, 3'd7, 6'b000011, 5);
    run(6'b100001, 2'b00, 3'd7, 6'b000000, 5);
    run(6'b011011, 2'b01, 3'd7, 6'b000000, 5);
    run(6'b101101, 2'b11, 3'd0, 6'b101101, 1);
    run(6'b110010, 2'b11, 3'd3, 6'b010110, 3);
    run(6'b000001, 2'b11, 3'd1, 6'b100000, 2);
    run(6'b100001, 2'b10, 3'd6, 6'b100001, 4);

    // stall in DONE with a competing request present
    req_data = 6'b000111; req_op = 2'b10; req_amt = 3'd2; req_valid = 1;
    @(negedge clk);
    req_data = 6'b111000;
    repeat (2) @(negedge clk);
    chk("stall_enter", 32'(rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_data", 32'(rsp_data), 32'(6'b011100));
      chk("stall_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("stall_release", 32'(busy), 0);

    // flush mid-SHIFT, with a request presented during flush
    req_data = 6'b111111; req_op = 2'b00; req_amt = 3'd6; req_valid = 1;
    @(negedge clk);
    chk("flush_pre_busy", 32'(busy), 1);
    flush = 1;
    #1;
    chk("flush_ready", 32'(req_ready), 0);
    @(negedge clk);
    flush = 0; req_valid = 0;
    chk("flush_idle", 32'({busy, rsp_valid}), 0);
    repeat (4) @(negedge clk);
    chk("flush_no_rsp", 32'({busy, rsp_valid}), 0);
    run(6'b010101, 2'b01, 3'd1, 6'b001010, 2);

    // flush beats a response handshake
    req_data = 6'b110000; req_op = 2'b00; req_amt = 3'd0; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    chk("fh_done", 32'(rsp_valid), 1);
    flush = 1; rsp_ready = 1;
    @(negedge clk);
    flush = 0; rsp_ready = 0;
    chk("fh_idle", 32'({busy, rsp_valid}), 0);

    // async reset mid-SHIFT
    req_data = 6'b101010; req_op = 2'b10; req_amt = 3'd5; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_data", 32'(rsp_data), 0);
    chk("ar_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(6'b100110, 2'b10, 3'd2, 6'b011010, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
